// File: rtl/line_buffer_responder_if.sv
// CPU word-access handshake plus pmem burst port for line_buffer_responder.
// master = requester/memory side, slave = the line buffer responder.
interface line_buffer_responder_if #(
    parameter int BEAT_W = 64
);
    logic              select;
    logic              write;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [3:0]        mbe;
    logic [31:0]       rdata;
    logic              resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [31:0]       pmem_address;
    logic [BEAT_W-1:0] pmem_wdata;
    logic [BEAT_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport master (
        output select, write, addr, wdata, mbe, pmem_rdata, pmem_resp,
        input  rdata, resp, pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport slave (
        input  select, write, addr, wdata, mbe, pmem_rdata, pmem_resp,
        output rdata, resp, pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/line_buffer_responder.sv
// Single-line write-back buffer answering CPU word accesses, refilling over pmem bursts.
// Optional hit/miss counters are enabled by defining LB_STATS_EN.
module line_buffer_responder #(
    parameter int BEAT_W     = 64,
    parameter int LINE_BEATS = 4
) (
    input logic clk,
    input logic rst_n,
    line_buffer_responder_if.slave bus
`ifdef LB_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int LINE_W = BEAT_W * LINE_BEATS;
    localparam int OFF    = $clog2(LINE_W / 8);
    localparam int CNT_W  = $clog2(LINE_BEATS);
    localparam int WORD_W = OFF - 2;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_BEATS - 1);

    typedef enum logic [1:0] {IDLE, WB, FILL, RESP} state_t;

    state_t            state, next_state;
    logic [LINE_W-1:0] line;
    logic [LINE_W-1:0] filled_line;
    logic              valid, dirty;
    logic [31-OFF:0]   tag;
    logic [CNT_W-1:0]  cnt;
    logic              req_write;
    logic [31:2]       req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_mbe;
    logic [31:0]       rdata_q;
    logic              hit;
    logic              accept;
    logic              last_beat;
    logic [WORD_W-1:0] req_word;

    function automatic logic [LINE_W-1:0] merge_word(input logic [LINE_W-1:0] l,
                                                     input logic [WORD_W-1:0] w,
                                                     input logic [31:0] d,
                                                     input logic [3:0] m);
        logic [LINE_W-1:0] r;
        r = l;
        for (int i = 0; i < 4; i++)
            if (m[i]) r[int'(w)*32 + i*8 +: 8] = d[i*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] read_word(input logic [LINE_W-1:0] l,
                                              input logic [WORD_W-1:0] w);
        return l[int'(w)*32 +: 32];
    endfunction

    assign hit       = valid && (bus.addr[31:OFF] == tag);
    assign accept    = (state == IDLE) && bus.select;
    assign last_beat = bus.pmem_resp && (cnt == LAST_BEAT);
    assign req_word  = req_addr[OFF-1:2];

    // The final fill beat and the pending access land in the same cycle, so build the completed line here.
    always_comb begin
        filled_line = line;
        filled_line[int'(cnt)*BEAT_W +: BEAT_W] = bus.pmem_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state       = state;
        bus.resp         = 1'b0;
        bus.rdata        = rdata_q;
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = '0;
        bus.pmem_wdata   = '0;
        case (state)
            IDLE: begin
                if (bus.select) next_state = hit ? RESP : (dirty ? WB : FILL);
            end
            WB: begin
                bus.pmem_write   = 1'b1;
                bus.pmem_address = {tag, {OFF{1'b0}}};
                bus.pmem_wdata   = line[int'(cnt)*BEAT_W +: BEAT_W];
                if (last_beat) next_state = FILL;
            end
            FILL: begin
                bus.pmem_read    = 1'b1;
                bus.pmem_address = {req_addr[31:OFF], {OFF{1'b0}}};
                if (last_beat) next_state = RESP;
            end
            RESP: begin
                bus.resp   = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept && hit && bus.write)
            line <= merge_word(line, bus.addr[OFF-1:2], bus.wdata, bus.mbe);
        else if (state == FILL && bus.pmem_resp)
            line <= (last_beat && req_write) ? merge_word(filled_line, req_word, req_wdata, req_mbe)
                                             : filled_line;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid     <= 1'b0;
            dirty     <= 1'b0;
            tag       <= '0;
            cnt       <= '0;
            req_write <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_mbe   <= '0;
            rdata_q   <= '0;
        end else begin
            if (accept) begin
                req_write <= bus.write;
                req_addr  <= bus.addr[31:2];
                req_wdata <= bus.wdata;
                req_mbe   <= bus.mbe;
                if (hit) begin
                    if (bus.write) dirty   <= 1'b1;
                    else           rdata_q <= read_word(line, bus.addr[OFF-1:2]);
                end
            end
            if ((state == WB || state == FILL) && bus.pmem_resp)
                cnt <= last_beat ? '0 : cnt + 1'b1;
            if (state == WB && last_beat)
                dirty <= 1'b0;
            if (state == FILL && last_beat) begin
                valid <= 1'b1;
                tag   <= req_addr[31:OFF];
                dirty <= req_write;
                if (!req_write) rdata_q <= read_word(filled_line, req_word);
            end
        end
    end

`ifdef LB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (accept) begin
            if (hit && hit_count != 32'hFFFF_FFFF)        hit_count  <= hit_count + 32'd1;
            else if (!hit && miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_line_buffer_responder.sv
// Randomized scoreboard bench for line_buffer_responder: a flat-memory model predicts read data,
// a single-line occupancy model predicts burst traffic and latency.
module tb_line_buffer_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    line_buffer_responder_if #(.BEAT_W(64)) bus();

`ifdef LB_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    line_buffer_responder #(.BEAT_W(64), .LINE_BEATS(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
`ifdef LB_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    typedef struct {
        bit          is_read;
        logic [31:0] data;
        bit          hit;
        int          resp_cyc;
        int          wb_base;
        int          fill_base;
        int          exp_wb;
        int          exp_fill;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [63:0] backing [logic [31:0]];
    int          tests = 0;
    int          errors = 0;
    int          cyc = 0;
    int          wb_beats = 0;
    int          fill_beats = 0;
    int          last_fill_cyc = 0;
    bit          m_valid = 0;
    bit          m_dirty = 0;
    logic [26:0] m_tag = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C ^ (a >> 7);
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        return ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
    endfunction

    function automatic logic [63:0] pmem_get(input logic [31:0] a8);
        return backing.exists(a8) ? backing[a8] : {init_word(a8 + 32'd4), init_word(a8)};
    endfunction

    // Burst memory: answers each beat after a random stall and records traffic for the scoreboard.
    initial begin : pmem_model
        int mem_beat;
        logic [31:0] ba;
        mem_beat = 0;
        bus.pmem_resp = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.pmem_resp = 1'b0;
            if (!rst_n || !(bus.pmem_read || bus.pmem_write)) begin
                mem_beat = 0;
                continue;
            end
            if ($urandom_range(0, 2) == 0) continue;
            ba = bus.pmem_address + 32'(mem_beat * 8);
            if (bus.pmem_write) begin
                backing[ba] = bus.pmem_wdata;
                wb_beats++;
            end else begin
                bus.pmem_rdata = pmem_get(ba);
                fill_beats++;
                last_fill_cyc = cyc;
            end
            bus.pmem_resp = 1'b1;
            mem_beat = (mem_beat + 1) % 4;
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.resp) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_resp", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    if (e.is_read) checkOutput("rdata", 64'(bus.rdata), 64'(e.data));
                    checkOutput("wb_beats", 64'(wb_beats - e.wb_base), 64'(e.exp_wb));
                    checkOutput("fill_beats", 64'(fill_beats - e.fill_base), 64'(e.exp_fill));
                    if (e.hit) checkOutput("hit_latency", 64'(cyc), 64'(e.resp_cyc));
                    else       checkOutput("miss_latency", 64'(cyc), 64'(last_fill_cyc + 1));
                end
            end
            if (rst_n && (bus.pmem_read || bus.pmem_write)) begin
                checkOutput("pmem_exclusive", 64'(bus.pmem_read & bus.pmem_write), 64'd0);
                checkOutput("pmem_align", 64'(bus.pmem_address[4:0]), 64'd0);
            end
        end
    end

    task automatic applyStimulus(input bit wr, input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] m, input bit chained, input bit keep);
        exp_t e;
        logic [26:0] t;
        logic [31:0] nw;
        bit got;
        if (!chained) begin
            @(posedge clk);
            #1;
        end
        bus.select = 1'b1;
        bus.write = wr;
        bus.addr = a;
        bus.wdata = d;
        bus.mbe = m;
        t = a[31:5];
        e.hit = m_valid && (m_tag == t);
        e.exp_wb = (!e.hit && m_dirty) ? 4 : 0;
        e.exp_fill = e.hit ? 0 : 4;
        if (!e.hit) begin
            m_valid = 1;
            m_tag = t;
            m_dirty = 0;
        end
        if (wr) begin
            m_dirty = 1;
            nw = ref_read(a);
            for (int i = 0; i < 4; i++)
                if (m[i]) nw[i*8 +: 8] = d[i*8 +: 8];
            ref_mem[{a[31:2], 2'b00}] = nw;
        end
        e.is_read = !wr;
        e.data = ref_read(a);
        e.resp_cyc = cyc + (chained ? 2 : 1);
        e.wb_base = wb_beats;
        e.fill_base = fill_beats;
        sb.push_back(e);
        got = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (bus.resp) begin
                got = 1;
                break;
            end
        end
        if (!got) checkOutput("resp_timeout", 64'd0, 64'd1);
        if (!keep) bus.select = 1'b0;
    endtask

    initial begin : stimulus
        logic [31:0] bases [4];
        int base;
        bit got;
        bit chain;
        bit keep;
        bases[0] = 32'h0000_0100;
        bases[1] = 32'h0000_2000;
        bases[2] = 32'h0001_0040;
        bases[3] = 32'hFFFF_FFE0;
        bus.select = 1'b0;
        bus.write = 1'b0;
        bus.addr = '0;
        bus.wdata = '0;
        bus.mbe = '0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_resp", 64'(bus.resp), 64'd0);
        checkOutput("reset_rdata", 64'(bus.rdata), 64'd0);
        checkOutput("reset_pmem_read", 64'(bus.pmem_read), 64'd0);
        checkOutput("reset_pmem_write", 64'(bus.pmem_write), 64'd0);
        checkOutput("reset_pmem_address", 64'(bus.pmem_address), 64'd0);
        checkOutput("reset_pmem_wdata", bus.pmem_wdata, 64'd0);
        rst_n = 1'b1;

        applyStimulus(0, 32'h0000_0104, '0, 4'h0, 0, 0);
        applyStimulus(1, 32'h0000_0108, 32'hAABB_CCDD, 4'b0101, 0, 0);
        applyStimulus(0, 32'h0000_0108, '0, 4'h0, 0, 0);
        applyStimulus(0, 32'h0000_2000, '0, 4'h0, 0, 0);
        applyStimulus(0, 32'h0000_0108, '0, 4'h0, 0, 0);
        applyStimulus(0, 32'h0000_0100, '0, 4'h0, 0, 1);
        applyStimulus(0, 32'h0000_011C, '0, 4'h0, 1, 0);

        // Reset two beats into a clean fill: the request vanishes and must refill from scratch.
        @(posedge clk);
        #1;
        bus.select = 1'b1;
        bus.write = 1'b0;
        bus.addr = 32'h0000_4000;
        base = fill_beats;
        got = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (fill_beats >= base + 2) begin
                got = 1;
                break;
            end
        end
        checkOutput("fill_two_beats", 64'(got), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.select = 1'b0;
        #1;
        checkOutput("midfill_pmem_read", 64'(bus.pmem_read), 64'd0);
        checkOutput("midfill_resp", 64'(bus.resp), 64'd0);
        checkOutput("midfill_pmem_address", 64'(bus.pmem_address), 64'd0);
        repeat (3) @(negedge clk);
        checkOutput("midfill_resp_held", 64'(bus.resp), 64'd0);
        sb.delete();
        m_valid = 0;
        m_dirty = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(0, 32'h0000_4000, '0, 4'h0, 0, 0);

        chain = 0;
        for (int n = 0; n < 150; n++) begin
            keep = ($urandom_range(0, 2) == 0);
            applyStimulus(1'($urandom_range(0, 1)),
                          bases[$urandom_range(0, 3)] + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3)),
                          $urandom, 4'($urandom_range(0, 15)), chain, keep);
            chain = keep;
        end
        bus.select = 1'b0;

        repeat (5) @(posedge clk);
        checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
